// File: rtl/intra_block_scheduler.sv
// rtl/intra_block_scheduler.sv - raster block dispatcher with round-robin engine grant
// Optional frame cycle counter enabled by defining IBS_FRAME_CYCLES_EN.
module intra_block_scheduler #(
    parameter  int NUM_ENG = 2,
    parameter  int FRAME_W = 1280,
    parameter  int FRAME_H = 720,
    parameter  int BLK     = 4,
    parameter  int COORD_W = 16,
    localparam int GID_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    input  logic [NUM_ENG-1:0] eng_req,
    input  logic [NUM_ENG-1:0] eng_done,
    output logic               grant_vld,
    output logic [NUM_ENG-1:0] grant_onehot,
    output logic [GID_W-1:0]   grant_id,
    output logic [COORD_W-1:0] blk_x,
    output logic [COORD_W-1:0] blk_y,
    output logic [NUM_ENG-1:0] eng_busy,
    output logic               busy,
    output logic               frame_done,
    output logic               err_spurious,
    output logic [31:0]        frame_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [GID_W-1:0]   rr_ptr;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;

    logic [NUM_ENG-1:0] eligible;
    logic               pick_vld;
    logic [GID_W-1:0]   pick_id;
    logic [GID_W-1:0]   next_ptr;
    logic               do_grant;
    logic [NUM_ENG-1:0] grant_mask;
    logic               row_end;
    logic               last_blk;

    // The registered grant_onehot masks the engine granted last cycle, whose req may still be high.
    assign eligible = eng_req & ~eng_busy & ~grant_onehot;

    // Two passes: first eligible at/after the pointer, then wrap to the low indices.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!pick_vld && eligible[i] && (i >= int'(rr_ptr))) begin
                pick_vld = 1'b1;
                pick_id  = GID_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!pick_vld && eligible[i]) begin
                pick_vld = 1'b1;
                pick_id  = GID_W'(i);
            end
        end
    end

    assign next_ptr   = (pick_id == GID_W'(NUM_ENG - 1)) ? '0 : pick_id + 1'b1;
    assign do_grant   = (state == S_DISPATCH) && !hold && pick_vld;
    assign grant_mask = do_grant ? (NUM_ENG'(1) << pick_id) : '0;
    assign row_end    = (cur_x == COORD_W'(FRAME_W - BLK));
    assign last_blk   = row_end && (cur_y == COORD_W'(FRAME_H - BLK));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            grant_vld    <= 1'b0;
            grant_onehot <= '0;
            grant_id     <= '0;
            blk_x        <= '0;
            blk_y        <= '0;
            eng_busy     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            grant_vld    <= 1'b0;
            grant_onehot <= '0;
            frame_done   <= 1'b0;
            eng_busy     <= (eng_busy & ~eng_done) | grant_mask;
            if (|(eng_done & ~eng_busy)) begin
                err_spurious <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_DISPATCH;
                        cur_x <= '0;
                        cur_y <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (do_grant) begin
                        grant_vld    <= 1'b1;
                        grant_onehot <= grant_mask;
                        grant_id     <= pick_id;
                        blk_x        <= cur_x;
                        blk_y        <= cur_y;
                        rr_ptr       <= next_ptr;
                        if (last_blk) begin
                            state <= S_DRAIN;
                        end else if (row_end) begin
                            cur_x <= '0;
                            cur_y <= cur_y + COORD_W'(BLK);
                        end else begin
                            cur_x <= cur_x + COORD_W'(BLK);
                        end
                    end
                end
                S_DRAIN: begin
                    if (eng_busy == '0) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IBS_FRAME_CYCLES_EN
    logic [31:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            cyc_cnt <= 32'd1;
        end else if (((state == S_DISPATCH) || (state == S_DRAIN)) && (cyc_cnt != 32'hFFFF_FFFF)) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    assign frame_cycles = cyc_cnt;
`else
    assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_intra_block_scheduler.sv
// tb/tb_intra_block_scheduler.sv - directed bench for intra_block_scheduler on a 16x8 plane
module tb_intra_block_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        hold;
    logic [1:0]  eng_req;
    logic [1:0]  eng_done;
    logic        grant_vld;
    logic [1:0]  grant_onehot;
    logic [0:0]  grant_id;
    logic [15:0] blk_x;
    logic [15:0] blk_y;
    logic [1:0]  eng_busy;
    logic        busy;
    logic        frame_done;
    logic        err_spurious;
    logic [31:0] frame_cycles;

    intra_block_scheduler #(
        .NUM_ENG (2),
        .FRAME_W (16),
        .FRAME_H (8),
        .BLK     (4),
        .COORD_W (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hold         (hold),
        .eng_req      (eng_req),
        .eng_done     (eng_done),
        .grant_vld    (grant_vld),
        .grant_onehot (grant_onehot),
        .grant_id     (grant_id),
        .blk_x        (blk_x),
        .blk_y        (blk_y),
        .eng_busy     (eng_busy),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_spurious (err_spurious),
        .frame_cycles (frame_cycles)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int n_grants;
    int n_done;
    int busy_viol;
    int hold_viol;
    int frame_len;
    int done_len;
    bit timeout;
    int g_id [16];
    int g_x  [16];
    int g_y  [16];
    int pend [2];
    int cnt  [2];

    int exp_x [8] = '{0, 4, 8, 12, 0, 4, 8, 12};
    int exp_y [8] = '{0, 0, 0, 0, 4, 4, 4, 4};

    // Engine model: done pulses two negedges after a grant is seen; dispatch is observed at negedges.
    task automatic run_frame(input logic [1:0] req_mask, input int hold_at, input int hold_len,
                             input int start_at, input int stop_at);
        int  hold_left;
        bit  stop;
        n_grants  = 0;
        n_done    = 0;
        busy_viol = 0;
        hold_viol = 0;
        done_len  = 0;
        timeout   = 1'b0;
        hold_left = 0;
        stop      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            cnt[i]  = 0;
        end
        eng_req  = req_mask;
        eng_done = 2'b00;
        hold     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        frame_len = 1;
        for (int c = 0; c < 400 && !stop; c++) begin
            if (frame_done) begin
                n_done++;
                done_len = frame_len;
                stop     = 1'b1;
            end
            start = 1'b0;
            if (grant_vld) begin
                if (hold) hold_viol++;
                for (int i = 0; i < 2; i++) begin
                    if (grant_onehot[i] && (pend[i] != 0 || eng_done[i])) busy_viol++;
                end
                if (n_grants < 16) begin
                    g_id[n_grants] = int'(grant_id);
                    g_x[n_grants]  = int'(blk_x);
                    g_y[n_grants]  = int'(blk_y);
                end
                n_grants++;
            end
            eng_done = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] != 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        eng_done[i] = 1'b1;
                        pend[i]     = 0;
                    end
                end
            end
            if (grant_vld) begin
                for (int i = 0; i < 2; i++) begin
                    if (grant_onehot[i]) begin
                        pend[i] = 1;
                        cnt[i]  = 2;
                    end
                end
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end
            if (grant_vld && n_grants == hold_at) begin
                hold      = 1'b1;
                hold_left = hold_len;
            end
            if (grant_vld && n_grants == start_at) start = 1'b1;
            if (grant_vld && n_grants == stop_at) stop = 1'b1;
            if (!stop) begin
                @(negedge clk);
                frame_len++;
            end
        end
        if (!stop) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        eng_req  = 2'b00;
        eng_done = 2'b00;
        repeat (3) @(negedge clk);
        tests++;
        if ({grant_vld, grant_onehot, grant_id, blk_x, blk_y, eng_busy, busy, frame_done,
             err_spurious, frame_cycles} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got vld=%b oh=%b id=%b x=%0d y=%0d eb=%b busy=%b fd=%b err=%b fc=%0d, want all 0",
                     grant_vld, grant_onehot, grant_id, blk_x, blk_y, eng_busy, busy, frame_done,
                     err_spurious, frame_cycles);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        run_frame(2'b11, -1, 0, -1, -1);
        tests++;
        if (timeout) begin
            fails++;
            $display("FAIL rr_timeout: frame_done not seen, grants=%0d, want frame end", n_grants);
        end
        tests++;
        if (n_grants !== 8) begin
            fails++;
            $display("FAIL rr_grant_count: got %0d, want 8", n_grants);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (g_id[k] !== (k % 2) || g_x[k] !== exp_x[k] || g_y[k] !== exp_y[k]) begin
                fails++;
                $display("FAIL rr_grant%0d: got id=%0d (%0d,%0d), want id=%0d (%0d,%0d)",
                         k, g_id[k], g_x[k], g_y[k], k % 2, exp_x[k], exp_y[k]);
            end
        end
        tests++;
        if (busy !== 1'b0 || eng_busy !== 2'b00) begin
            fails++;
            $display("FAIL rr_done_state: got busy=%b eng_busy=%b at frame_done, want 0 and 00", busy, eng_busy);
        end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || err_spurious !== 1'b0 || n_done !== 1) begin
            fails++;
            $display("FAIL rr_after: got frame_done=%b busy=%b err=%b done_count=%0d, want 0 0 0 1",
                     frame_done, busy, err_spurious, n_done);
        end
    endtask

    task automatic test_single_engine();
        run_frame(2'b10, -1, 0, -1, -1);
        tests++;
        if (timeout || n_grants !== 8 || n_done !== 1) begin
            fails++;
            $display("FAIL single_count: got grants=%0d done=%0d timeout=%0d, want 8 1 0", n_grants, n_done, timeout);
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (g_id[k] !== 1 || g_x[k] !== exp_x[k] || g_y[k] !== exp_y[k]) begin
                fails++;
                $display("FAIL single_grant%0d: got id=%0d (%0d,%0d), want id=1 (%0d,%0d)",
                         k, g_id[k], g_x[k], g_y[k], exp_x[k], exp_y[k]);
            end
        end
        tests++;
        if (busy_viol !== 0) begin
            fails++;
            $display("FAIL single_busy_overlap: got %0d grants to a busy engine, want 0", busy_viol);
        end
    endtask

    task automatic test_hold();
        run_frame(2'b11, 3, 5, -1, -1);
        tests++;
        if (hold_viol !== 0) begin
            fails++;
            $display("FAIL hold_grant: got %0d grants while hold=1, want 0", hold_viol);
        end
        tests++;
        if (g_x[3] !== 12 || g_y[3] !== 0) begin
            fails++;
            $display("FAIL hold_next_coord: got (%0d,%0d), want (12,0)", g_x[3], g_y[3]);
        end
        tests++;
        if (timeout || n_grants !== 8 || n_done !== 1) begin
            fails++;
            $display("FAIL hold_count: got grants=%0d done=%0d timeout=%0d, want 8 1 0", n_grants, n_done, timeout);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        eng_done = 2'b01;
        @(negedge clk);
        eng_done = 2'b00;
        tests++;
        if (err_spurious !== 1'b1 || eng_busy !== 2'b00) begin
            fails++;
            $display("FAIL spurious_set: got err=%b eng_busy=%b, want 1 00", err_spurious, eng_busy);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (err_spurious !== 1'b1) begin
            fails++;
            $display("FAIL spurious_sticky: got err=%b, want 1", err_spurious);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (err_spurious !== 1'b0) begin
            fails++;
            $display("FAIL spurious_clear: got err=%b after reset, want 0", err_spurious);
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(2'b11, -1, 0, -1, 3);
        @(negedge clk);
        reset    = 1'b1;
        eng_done = 2'b00;
        eng_req  = 2'b00;
        @(negedge clk);
        tests++;
        if ({grant_vld, grant_onehot, grant_id, blk_x, blk_y, eng_busy, busy, frame_done,
             err_spurious, frame_cycles} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got vld=%b oh=%b id=%b x=%0d y=%0d eb=%b busy=%b fd=%b err=%b fc=%0d, want all 0",
                     grant_vld, grant_onehot, grant_id, blk_x, blk_y, eng_busy, busy, frame_done,
                     err_spurious, frame_cycles);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_idle: got busy=%b frame_done=%b without start, want 0 0", busy, frame_done);
        end
        run_frame(2'b11, -1, 0, -1, -1);
        tests++;
        if (g_x[0] !== 0 || g_y[0] !== 0 || n_grants !== 8 || n_done !== 1 || timeout) begin
            fails++;
            $display("FAIL midreset_restart: got first (%0d,%0d) grants=%0d done=%0d timeout=%0d, want (0,0) 8 1 0",
                     g_x[0], g_y[0], n_grants, n_done, timeout);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        run_frame(2'b11, -1, 0, 2, -1);
        tests++;
        if (timeout || n_grants !== 8 || n_done !== 1) begin
            fails++;
            $display("FAIL restart_ignored: got grants=%0d done=%0d timeout=%0d, want 8 1 0", n_grants, n_done, timeout);
        end
`ifdef IBS_FRAME_CYCLES_EN
        tests++;
        if (frame_cycles !== 32'(done_len)) begin
            fails++;
            $display("FAIL frame_cycles: got %0d, want %0d", frame_cycles, done_len);
        end
`else
        tests++;
        if (frame_cycles !== 32'd0) begin
            fails++;
            $display("FAIL frame_cycles_off: got %0d, want 0", frame_cycles);
        end
`endif
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant_vld || busy) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL no_second_frame: got %0d active cycles after frame end, want 0", extra);
        end
`ifdef IBS_FRAME_CYCLES_EN
        tests++;
        if (frame_cycles !== 32'(done_len)) begin
            fails++;
            $display("FAIL frame_cycles_hold: got %0d, want %0d", frame_cycles, done_len);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_engine();
        test_hold();
        test_spurious();
        test_reset_mid_frame();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
